// File: rtl/painterengine_gpu_pkg.sv
// Shared types and constants for the PainterEngine GPU blend writer.
package painterengine_gpu_pkg;

    localparam int PIXEL_W         = 32;
    localparam int BYTES_PER_PIXEL = 4;
    localparam int BLENDER_LATENCY = 6;
    localparam int PAGE_BYTES      = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } bw_state_t;

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/painterengine_gpu_blend_writer_if.sv
// Burst memory write port: request/ack, beat data valid/ready/last, response pulse.
interface painterengine_gpu_blend_writer_if;
    import painterengine_gpu_pkg::*;

    logic               o_wire_wr_req;
    logic [31:0]        o_wire_wr_addr;
    logic [7:0]         o_wire_wr_len;
    logic               i_wire_wr_ack;
    logic [PIXEL_W-1:0] o_wire_wr_data;
    logic               o_wire_wr_valid;
    logic               i_wire_wr_ready;
    logic               o_wire_wr_last;
    logic               i_wire_wr_resp;

    modport master (
        output o_wire_wr_req, o_wire_wr_addr, o_wire_wr_len,
        output o_wire_wr_data, o_wire_wr_valid, o_wire_wr_last,
        input  i_wire_wr_ack, i_wire_wr_ready, i_wire_wr_resp
    );

    modport slave (
        input  o_wire_wr_req, o_wire_wr_addr, o_wire_wr_len,
        input  o_wire_wr_data, o_wire_wr_valid, o_wire_wr_last,
        output i_wire_wr_ack, i_wire_wr_ready, i_wire_wr_resp
    );

endinterface

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock FIFO with occupancy count. Head word is presented combinationally.
module painterengine_gpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     i_wire_clock,
    input  logic                     i_wire_reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    // A write while full is still legal when the same cycle pops a word.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge i_wire_clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH (power of 2); count tracks occupancy.
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (!do_wr && do_rd) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/painterengine_gpu_blend_writer.sv
// Blend writer: buffers the blender pixel stream and writes it out as bursts
// to consecutive framebuffer addresses. Optional macro BLEND_WRITER_4K_SPLIT_EN
// truncates bursts so none crosses a 4 KiB page.
module painterengine_gpu_blend_writer
    import painterengine_gpu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 64,
    parameter int BURST_LEN    = 16,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                            i_wire_clock,
    input  logic                            i_wire_reset,
    input  logic                            i_wire_start,
    input  logic [31:0]                     i_wire_dst_addr,
    input  logic [31:0]                     i_wire_pixel_count,
    input  logic [PIXEL_W-1:0]              i_wire_data_in,
    input  logic                            i_wire_data_valid,
    output logic                            o_wire_almost_full,
    output logic                            o_wire_overflow,
    output logic                            o_wire_busy,
    output logic                            o_wire_done,
    painterengine_gpu_blend_writer_if.master wr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (AFULL_MARGIN < BLENDER_LATENCY + 2) begin : g_bad_margin
        $error("AFULL_MARGIN must cover blender latency plus 2");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST_LEN) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2*BURST_LEN");
    end

    bw_state_t          state_q, state_d;
    logic [31:0]        addr_q, remaining_q, count_q, accepted_q, len_calc;
    logic [7:0]         len_q, beat_q;
    logic               overflow_q, done_q;
    logic [PIXEL_W-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty, fifo_rd;
    logic               in_job, pix_wr, pix_ovf, beat_last, beat_hs;

    // Pixels count against the job only while busy and below the job size.
    assign in_job    = i_wire_data_valid && o_wire_busy;
    assign pix_wr    = in_job && !fifo_full && (accepted_q < count_q);
    assign pix_ovf   = in_job && fifo_full;
    assign beat_last = (beat_q == len_q - 8'd1);
    assign beat_hs   = (state_q == ST_DATA) && wr.i_wire_wr_ready;

    painterengine_gpu_sync_fifo #(.WIDTH(PIXEL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_wire_clock (i_wire_clock),
        .i_wire_reset (i_wire_reset),
        .wr_en        (pix_wr),
        .wr_data      (i_wire_data_in),
        .rd_en        (fifo_rd),
        .rd_data      (fifo_head),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    // Burst length for the next request, optionally clipped at the page edge.
    always_comb begin
        len_calc = min32(32'(BURST_LEN), remaining_q);
`ifdef BLEND_WRITER_4K_SPLIT_EN
        len_calc = min32(len_calc,
                         (32'(PAGE_BYTES) - (addr_q & 32'(PAGE_BYTES - 1))) / 32'(BYTES_PER_PIXEL));
`endif
    end

    // State register.
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic and FIFO pop.
    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        unique case (state_q)
            ST_IDLE: if (i_wire_start) state_d = (i_wire_pixel_count == 32'd0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (32'(fifo_count) >= len_calc) state_d = ST_REQ;
            ST_REQ:  if (wr.i_wire_wr_ack) state_d = ST_DATA;
            ST_DATA: begin
                fifo_rd = wr.i_wire_wr_ready && !fifo_empty;
                if (wr.i_wire_wr_ready && beat_last) state_d = ST_RESP;
            end
            ST_RESP: if (wr.i_wire_wr_resp) state_d = (remaining_q == 32'd0) ? ST_DONE : ST_WAIT;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Job bookkeeping: address, remaining, accepted pixels, burst beat counter.
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            accepted_q  <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            if (state_q == ST_IDLE && i_wire_start) begin
                addr_q      <= i_wire_dst_addr & ~32'h3;
                remaining_q <= i_wire_pixel_count;
                count_q     <= i_wire_pixel_count;
                accepted_q  <= '0;
                overflow_q  <= 1'b0;
            end else begin
                if (pix_wr)  accepted_q <= accepted_q + 32'd1;
                if (pix_ovf) overflow_q <= 1'b1;
            end
            if (state_q == ST_WAIT && state_d == ST_REQ) begin
                len_q  <= len_calc[7:0];
                beat_q <= '0;
            end
            if (beat_hs) begin
                beat_q <= beat_q + 8'd1;
                if (beat_last) begin
                    addr_q      <= addr_q + (32'(len_q) << 2);
                    remaining_q <= remaining_q - 32'(len_q);
                end
            end
        end
    end

    assign o_wire_almost_full = (32'(FIFO_DEPTH) - 32'(fifo_count)) <= 32'(AFULL_MARGIN);
    assign o_wire_overflow    = overflow_q;
    assign o_wire_done        = done_q;
    assign o_wire_busy        = (state_q == ST_WAIT) || (state_q == ST_REQ) ||
                                (state_q == ST_DATA) || (state_q == ST_RESP);

    assign wr.o_wire_wr_req   = (state_q == ST_REQ);
    assign wr.o_wire_wr_addr  = (state_q == ST_REQ) ? addr_q : 32'd0;
    assign wr.o_wire_wr_len   = (state_q == ST_REQ) ? len_q - 8'd1 : 8'd0;
    assign wr.o_wire_wr_valid = (state_q == ST_DATA);
    assign wr.o_wire_wr_data  = (state_q == ST_DATA) ? fifo_head : '0;
    assign wr.o_wire_wr_last  = (state_q == ST_DATA) && beat_last;

endmodule

// File: tb/tb_painterengine_gpu_blend_writer.sv
// Directed bench for the blend writer: table of jobs plus hand sequences for
// count=0, overflow/almost-full, and reset mid-burst.
module tb_painterengine_gpu_blend_writer;
    import painterengine_gpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dst = '0, cnt = '0, din = '0;
    logic        dv = 1'b0;
    logic        afull, ovf, busy, done;

    painterengine_gpu_blend_writer_if wif();

    painterengine_gpu_blend_writer #(.FIFO_DEPTH(64), .BURST_LEN(16), .AFULL_MARGIN(8)) dut (
        .i_wire_clock       (clk),
        .i_wire_reset       (rst),
        .i_wire_start       (start),
        .i_wire_dst_addr    (dst),
        .i_wire_pixel_count (cnt),
        .i_wire_data_in     (din),
        .i_wire_data_valid  (dv),
        .o_wire_almost_full (afull),
        .o_wire_overflow    (ovf),
        .o_wire_busy        (busy),
        .o_wire_done        (done),
        .wr                 (wif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Memory slave model: records requests and beats, pulses resp after each burst.
    bit          slave_en = 1'b0;
    bit          stall_en = 1'b0;
    logic [31:0] got_addr[$];
    logic [7:0]  got_len[$];
    logic [31:0] got_data[$];

    initial begin : slave
        logic        p_req, p_ack, p_valid, p_ready, p_last, resp_pend;
        logic [31:0] p_addr, p_data;
        logic [7:0]  p_len, cur_len;
        int          beat;
        p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0; p_last = 0; resp_pend = 0;
        p_addr = 0; p_data = 0; p_len = 0; cur_len = 0; beat = 0;
        wif.i_wire_wr_ack = 1'b0; wif.i_wire_wr_ready = 1'b0; wif.i_wire_wr_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0; resp_pend = 0; beat = 0;
                wif.i_wire_wr_ack = 1'b0; wif.i_wire_wr_ready = 1'b0; wif.i_wire_wr_resp = 1'b0;
            end else begin
                wif.i_wire_wr_resp = resp_pend;
                resp_pend = 1'b0;
                if (p_valid && p_ready) begin
                    got_data.push_back(p_data);
                    chk("wr_last", {31'd0, p_last}, {31'd0, beat == int'(cur_len)});
                    if (beat == int'(cur_len)) resp_pend = 1'b1;
                    beat++;
                end
                if (p_req && p_ack) begin
                    got_addr.push_back(p_addr);
                    got_len.push_back(p_len);
                    cur_len = p_len;
                    beat = 0;
                end
                wif.i_wire_wr_ack   = slave_en && wif.o_wire_wr_req &&
                                      (!stall_en || $urandom_range(0, 1) == 1);
                wif.i_wire_wr_ready = slave_en && (!stall_en || $urandom_range(0, 2) != 0);
                p_req   = wif.o_wire_wr_req;   p_ack   = wif.i_wire_wr_ack;
                p_addr  = wif.o_wire_wr_addr;  p_len   = wif.o_wire_wr_len;
                p_valid = wif.o_wire_wr_valid; p_ready = wif.i_wire_wr_ready;
                p_data  = wif.o_wire_wr_data;  p_last  = wif.o_wire_wr_last;
            end
        end
    end

    typedef struct {
        logic [31:0]       addr;
        int                cnt;
        bit                stall;
        int                nb;
        logic [3:0][31:0]  baddr;
        logic [3:0][7:0]   blen;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input int c, input bit st, input int nb,
                                input logic [31:0] a0, input logic [7:0] l0,
                                input logic [31:0] a1, input logic [7:0] l1,
                                input logic [31:0] a2, input logic [7:0] l2);
        vec_t v;
        v.addr = addr; v.cnt = c; v.stall = st; v.nb = nb;
        v.baddr = '0; v.blen = '0;
        v.baddr[0] = a0; v.blen[0] = l0;
        v.baddr[1] = a1; v.blen[1] = l1;
        v.baddr[2] = a2; v.blen[2] = l2;
        return v;
    endfunction

    task automatic start_job(input logic [31:0] a, input int c);
        @(negedge clk);
        dst = a; cnt = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            dv = 1'b1; din = 32'hA000_0000 + i;
            @(negedge clk);
        end
        dv = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({name, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic check_bursts(input vec_t v, input int ndata);
        chk("n_bursts", got_addr.size(), v.nb);
        for (int b = 0; b < v.nb && b < got_addr.size(); b++) begin
            chk("burst_addr", got_addr[b], v.baddr[b]);
            chk("burst_len", {24'd0, got_len[b]}, {24'd0, v.blen[b]});
        end
        chk("n_beats", got_data.size(), ndata);
        for (int i = 0; i < ndata && i < got_data.size(); i++)
            chk("beat_data", got_data[i], 32'hA000_0000 + i);
    endtask

    task automatic clear_q();
        got_addr.delete(); got_len.delete(); got_data.delete();
    endtask

    task automatic run_vec(input vec_t v);
        clear_q();
        slave_en = 1'b1; stall_en = v.stall;
        start_job(v.addr, v.cnt);
        feed(v.cnt);
        wait_done("done");
        check_bursts(v, v.cnt);
    endtask

    vec_t vecs[5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t v;
        bit   hit;
        vecs[0] = mk(32'h0000_1000, 16, 0, 1, 32'h1000, 15, 0, 0, 0, 0);
        vecs[1] = mk(32'h0000_1000, 37, 1, 3, 32'h1000, 15, 32'h1040, 15, 32'h1080, 4);
        vecs[2] = mk(32'h0003_0002,  5, 0, 1, 32'h30000, 4, 0, 0, 0, 0);
        vecs[3] = mk(32'hFFFF_FFC0, 20, 1, 2, 32'hFFFF_FFC0, 15, 32'h0, 3, 0, 0);
`ifdef BLEND_WRITER_4K_SPLIT_EN
        vecs[4] = mk(32'h0000_0FF0, 16, 0, 2, 32'h0FF0, 3, 32'h1000, 11, 0, 0);
`else
        vecs[4] = mk(32'h0000_0FF0, 16, 0, 1, 32'h0FF0, 15, 0, 0, 0, 0);
`endif

        #1;
        chk("reset_outputs", {wif.o_wire_wr_req, wif.o_wire_wr_valid, wif.o_wire_wr_last,
                              afull, ovf, busy, done},
            32'd0);
        chk("reset_addr", wif.o_wire_wr_addr | wif.o_wire_wr_data | {24'd0, wif.o_wire_wr_len}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Empty job: done two cycles after start, no request.
        clear_q();
        start_job(32'h5000, 0);
        chk("cnt0_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("cnt0_done", {31'd0, done}, 32'd1);
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("cnt0_no_req", got_addr.size(), 0);

        // Fill the FIFO with the port stalled; check almost-full and overflow.
        clear_q();
        slave_en = 1'b0; stall_en = 1'b0;
        start_job(32'h4000, 64);
        for (int i = 0; i < 70; i++) begin
            dv = 1'b1; din = 32'hA000_0000 + i;
            @(negedge clk);
            if (i == 54) chk("afull_55", {31'd0, afull}, 32'd0);
            if (i == 55) chk("afull_56", {31'd0, afull}, 32'd1);
            if (i == 63) chk("ovf_64", {31'd0, ovf}, 32'd0);
            if (i == 64) chk("ovf_65", {31'd0, ovf}, 32'd1);
        end
        dv = 1'b0;
        slave_en = 1'b1;
        wait_done("ovf_done");
        v = mk(32'h4000, 64, 0, 4, 32'h4000, 15, 32'h4040, 15, 32'h4080, 15);
        v.baddr[3] = 32'h40C0; v.blen[3] = 8'd15;
        check_bursts(v, 64);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        start_job(32'h0, 0);
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        @(negedge clk); @(negedge clk);

        // Reset in the middle of a burst, then a clean 4-pixel job.
        clear_q();
        slave_en = 1'b1; stall_en = 1'b0;
        start_job(32'h3000, 16);
        feed(16);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk); #1;
            if (got_data.size() >= 5) hit = 1'b1;
        end
        chk("reached_beat5", {31'd0, hit}, 32'd1);
        chk("mid_burst", {31'd0, wif.o_wire_wr_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_outputs", {wif.o_wire_wr_req, wif.o_wire_wr_valid, wif.o_wire_wr_last,
                            afull, ovf, busy, done},
            32'd0);
        chk("rst_addr", wif.o_wire_wr_addr | wif.o_wire_wr_data | {24'd0, wif.o_wire_wr_len}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy) hit = 1'b1;
        end
        chk("rst_no_done", {31'd0, hit}, 32'd0);
        run_vec(mk(32'h2000, 4, 0, 1, 32'h2000, 3, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
